// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// The default geometry is also used by the instruction memory itself.
package instr_mem_loader_pkg;

  localparam int DEF_ADDR_W    = 7;
  localparam int DEF_MEM_BYTES = 128;
  localparam int DEF_RST_HOLD  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4,
    ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/loader_cksum.sv
// 8-bit modulo-256 byte accumulator with synchronous clear and enable.
// Kept generic so the data-memory loader can reuse it.
module loader_cksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      sum <= '0;
    else if (clr) sum <= '0;
    else if (en)  sum <= sum + din;
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a byte image into instruction memory, verifies its checksum and
// holds the CPU in reset until the image is good plus a fixed hold time.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int RST_HOLD  = DEF_RST_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] words_loaded
);

  localparam int HOLD_W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [ADDR_W:0]   MAX_LEN   = (ADDR_W + 1)'(MEM_BYTES);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-2:0] WORD_ONE  = (ADDR_W - 1)'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD);

  state_t            state, next_state;
  logic [ADDR_W:0]   byte_cnt;
  logic [ADDR_W:0]   load_len_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [7:0]        cksum;
  logic              accept, start_ok, start_fresh, last_byte;
  logic              cpu_rst_d, done_d, error_d;

  assign accept      = in_valid && in_ready;
  assign start_ok    = load_start && (state == IDLE || state == RUN || state == ERROR);
  assign start_fresh = start_ok && (load_len <= MAX_LEN);
  assign last_byte   = (byte_cnt == load_len_q - LEN_ONE);

  loader_cksum u_cksum (
    .clk (clk),
    .rst (rst),
    .clr (start_fresh),
    .en  (state == LOAD && accept),
    .din (in_data),
    .sum (cksum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, RUN, ERROR: begin
        if (load_start) begin
          if (load_len > MAX_LEN)  next_state = ERROR;
          else if (load_len == '0) next_state = CHECK;
          else                     next_state = LOAD;
        end
      end
      LOAD:    if (accept && last_byte) next_state = CHECK;
      CHECK:   if (accept) next_state = (in_data == cksum) ? HOLD : ERROR;
      HOLD:    if (hold_cnt == HOLD_LAST) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  // Status flags are decoded from next_state and registered, so they never glitch.
  always_comb begin
    in_ready  = (state == LOAD) || (state == CHECK);
    cpu_rst_d = (next_state != RUN);
    done_d    = (next_state == RUN);
    error_d   = (next_state == ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rst <= 1'b1;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      cpu_rst <= cpu_rst_d;
      done    <= done_d;
      error   <= error_d;
    end
  end

  // NOTE: only the write port registers reset here; the memory array is left untouched by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      byte_cnt     <= '0;
      load_len_q   <= '0;
      words_loaded <= '0;
      hold_cnt     <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) load_len_q <= load_len;
      if (start_fresh) begin
        byte_cnt     <= '0;
        words_loaded <= '0;
      end
      if (state == LOAD && accept) begin
        mem_we    <= 1'b1;
        mem_addr  <= byte_cnt[ADDR_W-1:0];
        mem_wdata <= in_data;
        byte_cnt  <= byte_cnt + LEN_ONE;
        if (byte_cnt[1:0] == 2'b11) words_loaded <= words_loaded + WORD_ONE;
      end
      hold_cnt <= (state == HOLD) ? hold_cnt + HOLD_ONE : '0;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table-driven image loads with a
// write scoreboard, plus hand-written async-reset and reload sequences.
module tb_instr_mem_loader;

  localparam int ADDR_W    = 7;
  localparam int MEM_BYTES = 128;
  localparam int RST_HOLD  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;
  logic [ADDR_W-2:0] words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t exp_q[$];

  typedef struct {
    int         len;
    int         sel;
    int         gap;
    logic [7:0] delta;
    bit         exp_done;
    bit         exp_err;
    int         exp_words;
  } vec_t;

  vec_t vecs[7];

  instr_mem_loader #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES),
    .RST_HOLD  (RST_HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .load_len     (load_len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every memory write must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  function automatic logic [7:0] img_byte(input int sel, input int i);
    logic [7:0] fixed_img [4];
    fixed_img = '{8'h20, 8'h08, 8'h00, 8'h05};
    if (sel == 0) return fixed_img[i % 4];
    return 8'((i * sel + 3) & 255);
  endfunction

  // Starts and ends on a falling edge; waits (bounded) for in_ready.
  task automatic send_byte(input logic [7:0] b, input int gaps, input bit is_data, input int addr);
    int cnt;
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
    end else if (is_data) begin
      exp_q.push_back('{addr: ADDR_W'(addr), data: b});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    load_start = 1'b1;
    load_len   = (ADDR_W + 1)'(len);
    @(negedge clk);
    load_start = 1'b0;
    check("start_cpu_rst", 32'(cpu_rst), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_error", 32'(error), (len > MEM_BYTES) ? 32'd1 : 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] sum;
    sum = 8'h00;
    pulse_start(v.len);
    if (v.len <= MEM_BYTES) begin
      for (int i = 0; i < v.len; i++) begin
        send_byte(img_byte(v.sel, i), (i > 0) ? v.gap : 0, 1'b1, i);
        sum = sum + img_byte(v.sel, i);
      end
      send_byte(sum + v.delta, 0, 1'b0, 0);
    end else begin
      check("badlen_ready", 32'(in_ready), 32'd0);
    end
    if (v.exp_done) begin
      // Offer a stray byte during HOLD; it must not be accepted or written.
      in_valid = 1'b1;
      in_data  = 8'hAA;
      for (int k = 0; k < RST_HOLD + 1; k++) begin
        check("hold_cpu_rst", 32'(cpu_rst), 32'd1);
        check("hold_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
      end
      in_valid = 1'b0;
      check("run_cpu_rst", 32'(cpu_rst), 32'd0);
    end
    check("final_done", 32'(done), 32'(v.exp_done));
    check("final_error", 32'(error), 32'(v.exp_err));
    check("final_cpu_rst", 32'(cpu_rst), v.exp_done ? 32'd0 : 32'd1);
    check("words_loaded", 32'(words_loaded), 32'(v.exp_words));
    check("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    //          len  sel gap delta  done err words
    vecs[0] = '{4,   0,  0,  8'h00, 1,   0,  1};   // 20 08 00 05, cksum 2D
    vecs[1] = '{4,   0,  0,  8'hFF, 0,   1,  1};   // cksum 2C, reload from RUN
    vecs[2] = '{6,   5,  2,  8'h00, 1,   0,  1};   // valid 1,0,0,1,... gaps
    vecs[3] = '{0,   0,  0,  8'h00, 1,   0,  0};   // empty image, cksum 00
    vecs[4] = '{128, 3,  0,  8'h00, 1,   0,  32};  // full memory, last addr 127
    vecs[5] = '{129, 0,  0,  8'h00, 0,   1,  32};  // oversize, counters untouched
    vecs[6] = '{7,   11, 1,  8'h10, 0,   1,  1};   // partial word, bad cksum

    rst        = 1'b1;
    load_start = 1'b0;
    load_len   = '0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    #1;
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd0);

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // Async reset partway through a load: outputs drop without a clock edge.
    pulse_start(8);
    for (int i = 0; i < 3; i++) send_byte(img_byte(9, i), 0, 1'b1, i);
    #2 rst = 1'b1;
    #1;
    check("arst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_words", 32'(words_loaded), 32'd0);
    check("arst_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Fresh load must restart at address 0 and verify normally.
    run_vec(vecs[0]);
    // Reload straight from RUN with a different image.
    run_vec(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Boot-time program loader that sits directly upstream of mips_single. It accepts a byte stream over a valid/ready handshake and writes it, one byte per address, into the instruction memory array. The array is byte-addressed and little-endian, one byte per entry, the same layout as instr_mem.txt. The block holds the CPU in reset until the image is loaded and its checksum verifies, then releases the CPU after a fixed hold count.

Parameters:
ADDR_W, 7, byte address width of instruction memory
MEM_BYTES, 128, instruction memory capacity in bytes (must be <= 2**ADDR_W)
RST_HOLD, 4, cycles cpu_rst stays high after a successful checksum before release

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
load_start  input  1  one-cycle pulse to begin a load
load_len  input  ADDR_W+1  number of image bytes, sampled on load_start
in_valid  input  1  stream byte valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts in_data this cycle
mem_we  output  1  instruction memory byte write enable
mem_addr  output  ADDR_W  instruction memory byte address
mem_wdata  output  8  instruction memory write byte
cpu_rst  output  1  reset to mips_single, active-high
done  output  1  image loaded, verified and CPU released
error  output  1  load failed; sticky until the next load_start or rst
words_loaded  output  ADDR_W-1  count of complete 4-byte words written

Behaviour:
- Reset is asynchronous and active-high. On reset, all state clears regardless of the current state:
  - state=IDLE
  - cpu_rst=1, done=0, error=0, in_ready=0
  - mem_we=0, mem_addr=0, mem_wdata=0
  - words_loaded=0, byte count=0, checksum accumulator=0, hold count=0
- A handshake is accepted when in_valid and in_ready are both high at a clock edge.
- States:
  - IDLE: cpu_rst=1, in_ready=0. On load_start:
    - if load_len > MEM_BYTES, go to ERROR;
    - else if load_len == 0, go to CHECK;
    - else go to LOAD.
    - Entering LOAD or CHECK clears the byte count, the checksum and words_loaded.
  - LOAD: in_ready=1. For each accepted byte, the next cycle has mem_we=1, mem_addr=byte count, mem_wdata=byte. The write has exactly one cycle of latency.
    - The checksum accumulates as an 8-bit sum, mod 256.
    - words_loaded increments whenever byte count[1:0] was 3 at acceptance.
    - After byte load_len-1 is accepted, go to CHECK.
    - A partial final word is written as-is; words_loaded does not count it.
  - CHECK: in_ready=1. The accepted byte is the checksum and is never written to memory.
    - If it equals the accumulator, go to HOLD; otherwise go to ERROR.
  - HOLD: in_ready=0, cpu_rst=1. Counts RST_HOLD cycles, then goes to RUN.
  - RUN: cpu_rst=0, done=1, in_ready=0.
  - ERROR: error=1, cpu_rst=1, in_ready=0.
- load_start handling:
  - Ignored in LOAD, CHECK and HOLD.
  - In RUN or ERROR, load_start behaves exactly as in IDLE. It clears done and error and reasserts cpu_rst in the following cycle.
- mem_we is never high for two writes to the same address within one load. Writes stop after load_len bytes even if in_valid stays high.
- A stalled stream (in_valid low) holds all state indefinitely; there is no timeout.
- rst asserted mid-LOAD leaves partially written memory untouched. Only control state resets.
- Outputs done, error and cpu_rst are registered and glitch-free.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE, LOAD, CHECK, HOLD, RUN, ERROR);
  - the default ADDR_W and MEM_BYTES, shared with the instruction memory module.
- One sub-module is natural: loader_cksum, an 8-bit accumulator with clear and enable. It is reused later by a data-memory loader.

Test Plan:
- Normal load: load_len=4, bytes 20,08,00,05, checksum 2D.
  - Required: writes addr0..3 with 20,08,00,05; words_loaded=1.
  - Required: cpu_rst falls exactly RST_HOLD+1 cycles after checksum acceptance; done=1.
- Bad checksum: same image, checksum 2C.
  - Required: error=1, cpu_rst stays 1, done=0, no write on the checksum byte.
- Backpressure and gaps: load_len=6, with in_valid toggled 1,0,0,1,...
  - Required: exactly 6 writes, to addr0..5 in order; words_loaded=1.
  - Required: an extra valid byte after the checksum is not accepted (in_ready=0).
- Boundaries:
  - load_len=0 with checksum 00 -> reaches RUN with no writes.
  - load_len=MEM_BYTES+1 -> ERROR on the next cycle with no writes.
  - load_len=MEM_BYTES -> last write at addr 127.
- Async reset mid-LOAD after 3 bytes:
  - Required: outputs return to reset values immediately without waiting for a clock edge.
  - Required: a fresh load_start then restarts at addr0.
- Reload from RUN: load_start while done=1.
  - Required: cpu_rst=1 and done=0 the next cycle, then a second image loads and verifies normally.
